// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS subset: FSM states, opcodes, Funct codes
// and the 2-bit ALU control word consumed by the ALU.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;

    typedef enum logic [1:0] {
        ALU_AND = 2'b00,
        ALU_OR  = 2'b01,
        ALU_ADD = 2'b10,
        ALU_SUB = 2'b11
    } alu_ctl_t;

    // 2'b11 is unused by the controller and decodes as ADD.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALUOp and the instruction Funct field to the ALU control word.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [5:0]  funct,
    output alu_ctl_t    alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// The current state is exported on State for debug and checker binding.
module multicycle_control
    import mips_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    output logic [1:0]  ALUControl,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic        IorD,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        PCEn,
    output logic [3:0]  State
);

    state_t   state_q;
    state_t   state_d;
    alu_op_t  alu_op;
    alu_ctl_t alu_ctl;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Opcode is looked at again here to pick the load or store path.
            S_MEMADR: begin
                if (Opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (Opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op   = ALUOP_ADD;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        IorD     = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        PCEn     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = 1'b1;
                PCEn    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR, S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMREAD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            // The only input-dependent output: branch taken when the SUB result is zero.
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                PCEn    = Zero;
            end
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (alu_ctl)
    );

    assign ALUControl = alu_ctl;
    assign State      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks every instruction class and the
// asynchronous reset, comparing State and the full control word against hand-written values.
module tb_multicycle_control;

    logic       Clk;
    logic       Reset;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic [1:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       RegDst;
    logic       MemtoReg;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       PCEn;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    // Control word order: IorD, ALUSrcA, ALUSrcB, PCSrc, RegDst, MemtoReg,
    // IRWrite, MemWrite, RegWrite, PCEn, ALUControl.
    localparam logic [13:0] C_FETCH    = 14'b0_0_01_00_0_0_1_0_0_1_10;
    localparam logic [13:0] C_DECODE   = 14'b0_0_11_00_0_0_0_0_0_0_10;
    localparam logic [13:0] C_MEMADR   = 14'b0_1_10_00_0_0_0_0_0_0_10;
    localparam logic [13:0] C_MEMREAD  = 14'b1_0_00_00_0_0_0_0_0_0_10;
    localparam logic [13:0] C_MEMWB    = 14'b0_0_00_00_0_1_0_0_1_0_10;
    localparam logic [13:0] C_MEMWRITE = 14'b1_0_00_00_0_0_0_1_0_0_10;
    localparam logic [13:0] C_EXEC_ADD = 14'b0_1_00_00_0_0_0_0_0_0_10;
    localparam logic [13:0] C_EXEC_SUB = 14'b0_1_00_00_0_0_0_0_0_0_11;
    localparam logic [13:0] C_EXEC_AND = 14'b0_1_00_00_0_0_0_0_0_0_00;
    localparam logic [13:0] C_EXEC_OR  = 14'b0_1_00_00_0_0_0_0_0_0_01;
    localparam logic [13:0] C_ALUWB    = 14'b0_0_00_00_1_0_0_0_1_0_10;
    localparam logic [13:0] C_BR_TAKEN = 14'b0_1_00_01_0_0_0_0_0_1_11;
    localparam logic [13:0] C_BR_NOT   = 14'b0_1_00_01_0_0_0_0_0_0_11;
    localparam logic [13:0] C_ADDIWB   = 14'b0_0_00_00_0_0_0_0_1_0_10;
    localparam logic [13:0] C_JUMP     = 14'b0_0_00_10_0_0_0_0_0_1_10;

    logic [13:0] ctl;
    assign ctl = {IorD, ALUSrcA, ALUSrcB, PCSrc, RegDst, MemtoReg,
                  IRWrite, MemWrite, RegWrite, PCEn, ALUControl};

    multicycle_control dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .Zero       (Zero),
        .ALUControl (ALUControl),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .IorD       (IorD),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .PCEn       (PCEn),
        .State      (State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Check the current state and control word without advancing the clock.
    task automatic look(input string tag, input logic [3:0] exp_state, input logic [13:0] exp_ctl);
        check({tag, "_state"}, {10'd0, State}, {10'd0, exp_state});
        check({tag, "_ctl"}, ctl, exp_ctl);
    endtask

    // Advance one clock edge, then sample 2 time units later.
    task automatic step(input string tag, input logic [3:0] exp_state, input logic [13:0] exp_ctl);
        @(posedge Clk);
        #2;
        look(tag, exp_state, exp_ctl);
    endtask

    task automatic rtype(input string tag, input logic [5:0] funct, input logic [13:0] exec_ctl);
        Opcode = 6'b000000;
        Funct  = funct;
        step({tag, "_decode"}, 4'd1, C_DECODE);
        step({tag, "_execute"}, 4'd6, exec_ctl);
        step({tag, "_aluwb"}, 4'd7, C_ALUWB);
        step({tag, "_fetch"}, 4'd0, C_FETCH);
    endtask

    initial begin
        Reset  = 1'b1;
        Opcode = 6'b000000;
        Funct  = 6'b000000;
        Zero   = 1'b0;
        #2;
        look("reset_hold", 4'd0, C_FETCH);
        @(posedge Clk);
        #2;
        look("reset_edge", 4'd0, C_FETCH);
        Reset = 1'b0;
        #1;
        look("reset_release", 4'd0, C_FETCH);

        // lw: 5 cycles, register write only in the last
        Opcode = 6'b100011;
        step("lw_decode", 4'd1, C_DECODE);
        step("lw_memadr", 4'd2, C_MEMADR);
        step("lw_memread", 4'd3, C_MEMREAD);
        step("lw_memwb", 4'd4, C_MEMWB);
        step("lw_fetch", 4'd0, C_FETCH);

        // sw: 4 cycles
        Opcode = 6'b101011;
        step("sw_decode", 4'd1, C_DECODE);
        step("sw_memadr", 4'd2, C_MEMADR);
        step("sw_memwrite", 4'd5, C_MEMWRITE);
        step("sw_fetch", 4'd0, C_FETCH);

        // R-type with each Funct decode, plus an unknown Funct falling back to ADD
        rtype("r_sub", 6'b100010, C_EXEC_SUB);
        rtype("r_add", 6'b100000, C_EXEC_ADD);
        rtype("r_and", 6'b100100, C_EXEC_AND);
        rtype("r_or", 6'b100101, C_EXEC_OR);
        rtype("r_unk", 6'b111000, C_EXEC_ADD);

        // beq taken, then Zero dropped inside BRANCH to see PCEn follow it
        Opcode = 6'b000100;
        Zero   = 1'b1;
        step("beq1_decode", 4'd1, C_DECODE);
        step("beq1_branch", 4'd8, C_BR_TAKEN);
        Zero = 1'b0;
        #1;
        look("beq1_zero_drop", 4'd8, C_BR_NOT);
        Zero = 1'b1;
        step("beq1_fetch", 4'd0, C_FETCH);

        // beq not taken
        Zero = 1'b0;
        step("beq0_decode", 4'd1, C_DECODE);
        step("beq0_branch", 4'd8, C_BR_NOT);
        step("beq0_fetch", 4'd0, C_FETCH);

        // addi: 4 cycles
        Opcode = 6'b001000;
        step("addi_decode", 4'd1, C_DECODE);
        step("addi_exec", 4'd9, C_MEMADR);
        step("addi_wb", 4'd10, C_ADDIWB);
        step("addi_fetch", 4'd0, C_FETCH);

        // j: 3 cycles
        Opcode = 6'b000010;
        step("j_decode", 4'd1, C_DECODE);
        step("j_jump", 4'd11, C_JUMP);
        step("j_fetch", 4'd0, C_FETCH);

        // unsupported opcode: 2-cycle NOP
        Opcode = 6'b111111;
        step("nop_decode", 4'd1, C_DECODE);
        step("nop_fetch", 4'd0, C_FETCH);

        // sw interrupted by asynchronous reset in MEMADR
        Opcode = 6'b101011;
        step("swr_decode", 4'd1, C_DECODE);
        step("swr_memadr", 4'd2, C_MEMADR);
        #1;
        Reset = 1'b1;
        #1;
        look("swr_async", 4'd0, C_FETCH);
        @(posedge Clk);
        #2;
        look("swr_held", 4'd0, C_FETCH);
        Reset = 1'b0;
        #1;
        look("swr_release", 4'd0, C_FETCH);
        step("swr_decode2", 4'd1, C_DECODE);
        step("swr_memadr2", 4'd2, C_MEMADR);
        step("swr_memwrite2", 4'd5, C_MEMWRITE);
        step("swr_fetch2", 4'd0, C_FETCH);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have no parameters; all encodings are fixed constants.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: Clk input 1, rising-edge clock; Reset input 1, asynchronous, active-high.
REQ-003 SHALL have port Opcode, input, 6 bits: instruction bits 31:26 from the external instruction register, stable from the cycle after FETCH onward.
REQ-004 SHALL have port Funct, input, 6 bits: instruction bits 5:0.
REQ-005 SHALL have port Zero, input, 1 bit: ALU zero flag, valid when ALUControl=SUB.
REQ-006 SHALL have port ALUControl, output, 2 bits, encoded AND=00, OR=01, ADD=10, SUB=11.
REQ-007 SHALL have outputs ALUSrcA (1), ALUSrcB (2), PCSrc (2), IorD (1), RegDst (1) and MemtoReg (1): datapath mux selects.
REQ-008 SHALL have outputs IRWrite, MemWrite, RegWrite and PCEn, 1 bit each: write enables.
REQ-009 SHALL have port State, output, 4 bits: current state, for debug and verification.

Function
REQ-010 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; PCEn in BRANCH is the only output that depends on an input.
REQ-011 SHALL advance one state per Clk edge: FETCH->DECODE in all cases.
REQ-012 SHALL go from DECODE, by Opcode, to: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXECUTE; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEXEC; 000010 (j) -> JUMP; any other opcode -> FETCH (executes as a NOP).
REQ-013 SHALL go MEMADR->MEMREAD for lw and MEMADR->MEMWRITE for sw, with Opcode re-sampled in MEMADR.
REQ-014 SHALL make these transitions: MEMREAD->MEMWB, EXECUTE->ALUWB, ADDIEXEC->ADDIWB; MEMWB, MEMWRITE, ALUWB, ADDIWB, BRANCH and JUMP all -> FETCH.
REQ-015 SHALL take these cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported opcode 2.
REQ-016 SHALL drive, in FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=00, IRWrite=1, PCEn=1.
REQ-017 SHALL drive, in DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=ADD (branch target computed).
REQ-018 SHALL drive, in MEMADR and ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD.
REQ-019 SHALL drive IorD=1 in MEMREAD, IorD=1 with MemWrite=1 in MEMWRITE, and RegDst=0, MemtoReg=1, RegWrite=1 in MEMWB.
REQ-020 SHALL drive, in EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl decoded from Funct: 100000->ADD, 100010->SUB, 100100->AND, 100101->OR; any other Funct->ADD.
REQ-021 SHALL drive RegDst=1, MemtoReg=0, RegWrite=1 in ALUWB, and RegDst=0, MemtoReg=0, RegWrite=1 in ADDIWB.
REQ-022 SHALL drive, in BRANCH: ALUSrcA=1, ALUSrcB=00, ALUControl=SUB, PCSrc=01, PCEn=Zero (combinational).
REQ-023 SHALL drive, in JUMP: PCSrc=10, PCEn=1.
REQ-024 SHALL drive every output not listed for a state to 0 in that state; ALUControl defaults to ADD (10).
REQ-025 SHALL assert at most one of IRWrite, MemWrite and RegWrite in any cycle.
REQ-026 SHALL never hold an illegal State value (12-15); if one occurs, the next state SHALL be FETCH.

Reset
REQ-027 SHALL force State=FETCH immediately while Reset=1, independent of Clk, and drive FETCH outputs (IRWrite=1, PCEn=1) during reset.
REQ-028 SHALL abandon a mid-instruction reset with no partial write after release; the first edge after release SHALL go FETCH->DECODE.

Structure
REQ-029 SHALL place the state encodings, opcode constants, Funct constants and ALUControl encodings in shared package mips_pkg, also used by the ALU.
REQ-030 SHALL implement the Funct/ALUOp-to-ALUControl mapping as sub-module alu_decoder (2-bit ALUOp: 00=ADD, 01=SUB, 10=use Funct).

Verification
REQ-031 SHALL cover lw (Opcode=100011): State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in cycle 5.
REQ-032 SHALL cover R-type sub (Opcode=000000, Funct=100010): ALUControl=11 in EXECUTE, then RegDst=1 and RegWrite=1 in ALUWB, back to FETCH after 4 cycles.
REQ-033 SHALL cover beq (Opcode=000100) with Zero=1, giving PCEn=1 and PCSrc=01 in BRANCH, and repeat with Zero=0, giving PCEn=0; both return to FETCH.
REQ-034 SHALL cover unsupported opcode 111111: State sequence 0,1,0 with no MemWrite and no RegWrite.
REQ-035 SHALL cover sw: Reset asserted asynchronously in MEMADR gives State=0 before the next Clk edge, and MemWrite is never asserted.
REQ-036 SHALL cover j (Opcode=000010): PCSrc=10 and PCEn=1 in JUMP, 3 cycles total.
